imm_gen_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational immediate extender. Decodes the RV32I/RV64I immediate for a given format and sign-extends it to XLEN. Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the decode stage can stall without a combinational ready path. Sits between instruction decode and the ID/EX pipeline register and carries a sideband tag (PC or ROB index) alongside the immediate.

---
 rtl/imm_gen_pipe_if.sv | 37 +++
 rtl/imm_gen_pipe.sv | 176 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: upstream decode side and downstream ID/EX side.
// Carries Illegal_o when IMM_ILLEGAL_EN is defined.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);
  logic              Valid_i;
  logic              Ready_o;
  logic [31:0]       Instruction_i;
  logic [2:0]        Format_i;
  logic [TAG_W-1:0]  Tag_i;
  logic              Valid_o;
  logic              Ready_i;
  logic [XLEN-1:0]   Immediate_o;
  logic [TAG_W-1:0]  Tag_o;
`ifdef IMM_ILLEGAL_EN
  logic              Illegal_o;
`endif

  // Block-side view.
  modport slave (
    input  Valid_i, Instruction_i, Format_i, Tag_i, Ready_i,
`ifdef IMM_ILLEGAL_EN
    output Illegal_o,
`endif
    output Ready_o, Valid_o, Immediate_o, Tag_o
  );

  // Environment-side view.
  modport master (
    output Valid_i, Instruction_i, Format_i, Tag_i, Ready_i,
`ifdef IMM_ILLEGAL_EN
    input  Illegal_o,
`endif
    input  Ready_o, Valid_o, Immediate_o, Tag_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate extender with a 2-entry skid buffer and sideband tag.
// Optional IMM_ILLEGAL_EN adds a registered Illegal_o flag per entry.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic           Clk_i,
  input  logic           Rst_ni,
  input  logic           Flush_i,
  imm_gen_pipe_if.slave  bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  logic [31:0]      w_ins;
  logic [2:0]       w_fmt;
  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;
  logic             w_unused_opcode;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_main_valid;
  logic             r_ready;
  logic             w_accept;
  logic             w_pop;
  logic             w_ld_main_in;
  logic             w_ld_main_skid;
  logic             w_ld_skid;

  logic [XLEN-1:0]  r_main_imm;
  logic [TAG_W-1:0] r_main_tag;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;

  assign w_ins           = bus.Instruction_i;
  assign w_fmt           = bus.Format_i;
  assign w_unused_opcode = ^w_ins[6:0];

  // Immediate decode to 32 bits; bit 31 of the instruction is always the sign.
  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      3'd1:    w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
      3'd2:    w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      3'd3:    w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25],
                          w_ins[11:8], 1'b0};
      3'd4:    w_imm32 = {w_ins[31:12], 12'h000};
      3'd5:    w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20],
                          w_ins[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

`ifdef IMM_ILLEGAL_EN
  logic w_illegal;
  logic r_main_ill;
  logic r_skid_ill;

  assign w_illegal = (w_fmt[2] & w_fmt[1]) | (w_ins[1:0] != 2'b11);
  assign w_imm     = w_illegal ? '0 : XLEN'($signed(w_imm32));
`else
  assign w_imm     = XLEN'($signed(w_imm32));
`endif

  assign w_accept = bus.Valid_i & r_ready;
  assign w_pop    = r_main_valid & bus.Ready_i;

  // Occupancy state machine: EMPTY, main only, main plus skid.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (Flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_ld_main_in = 1'b1;
            w_state_nxt  = ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (w_pop) begin
            if (w_accept) begin
              w_ld_main_in = 1'b1;
            end else begin
              w_state_nxt = ST_EMPTY;
            end
          end else if (w_accept) begin
            w_ld_skid   = 1'b1;
            w_state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_ld_main_skid = 1'b1;
            w_state_nxt    = ST_MAIN;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Valid/ready flops follow the next occupancy so neither output has a comb path.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      r_state      <= ST_EMPTY;
      r_main_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_main_valid <= (w_state_nxt != ST_EMPTY);
      r_ready      <= (w_state_nxt != ST_FULL);
    end
  end

  // Payload registers load only on a transfer, holding Immediate_o steady under stall.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      r_main_imm <= '0;
      r_main_tag <= '0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_imm <= w_imm;
        r_main_tag <= bus.Tag_i;
      end else if (w_ld_main_skid) begin
        r_main_imm <= r_skid_imm;
        r_main_tag <= r_skid_tag;
      end
      if (w_ld_skid) begin
        r_skid_imm <= w_imm;
        r_skid_tag <= bus.Tag_i;
      end
    end
  end

`ifdef IMM_ILLEGAL_EN
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      r_main_ill <= 1'b0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_ld_main_in) begin
        r_main_ill <= w_illegal;
      end else if (w_ld_main_skid) begin
        r_main_ill <= r_skid_ill;
      end
      if (w_ld_skid) begin
        r_skid_ill <= w_illegal;
      end
    end
  end

  assign bus.Illegal_o = r_main_ill;
`endif

  assign bus.Ready_o     = r_ready;
  assign bus.Valid_o     = r_main_valid;
  assign bus.Immediate_o = r_main_imm;
  assign bus.Tag_o       = r_main_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep
// and checked against a queue-based occupancy model plus fixed decode vectors.
module tb_imm_gen_pipe;
  localparam int unsigned TW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          v_i   = 1'b0;
  logic          r_i   = 1'b1;
  logic [31:0]   ins   = '0;
  logic [2:0]    fmt   = '0;
  logic [TW-1:0] tag   = '0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(TW)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(TW)) b64 ();

  assign b32.Valid_i = v_i;  assign b64.Valid_i = v_i;
  assign b32.Ready_i = r_i;  assign b64.Ready_i = r_i;
  assign b32.Instruction_i = ins;  assign b64.Instruction_i = ins;
  assign b32.Format_i = fmt;  assign b64.Format_i = fmt;
  assign b32.Tag_i = tag;  assign b64.Tag_i = tag;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TW)) u_dut32 (
    .Clk_i(clk), .Rst_ni(rst_n), .Flush_i(flush), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(TW)) u_dut64 (
    .Clk_i(clk), .Rst_ni(rst_n), .Flush_i(flush), .bus(b64.slave));

  typedef struct {
    logic [63:0]   imm;
    logic [TW-1:0] tag;
    logic          ill;
  } ent_t;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  fmt;
    logic [31:0] e32;
    logic [63:0] e64;
  } vec_t;

  ent_t mq[$];
  vec_t tv[10];
  int   errs   = 0;
  int   checks = 0;

  // Immediate rules written directly at 64 bits; the 32-bit result is the low half.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] f);
    logic [63:0] r;
    logic        s;
    s = w[31];
    case (f)
      3'd1:    r = {{52{s}}, w[31:20]};
      3'd2:    r = {{52{s}}, w[31:25], w[11:7]};
      3'd3:    r = {{51{s}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    r = {{32{s}}, w[31:12], 12'h000};
      3'd5:    r = {{43{s}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: r = 64'h0;
    endcase
`ifdef IMM_ILLEGAL_EN
    if (f >= 3'd6 || w[1:0] != 2'b11) r = 64'h0;
`endif
    return r;
  endfunction

  function automatic logic ref_ill(input logic [31:0] w, input logic [2:0] f);
    return (f >= 3'd6) || (w[1:0] != 2'b11);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("ready32", 64'(b32.Ready_o), 64'(mq.size() < 2));
    chk("ready64", 64'(b64.Ready_o), 64'(mq.size() < 2));
    chk("valid32", 64'(b32.Valid_o), 64'(mq.size() > 0));
    chk("valid64", 64'(b64.Valid_o), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("imm32", 64'(b32.Immediate_o), 64'(mq[0].imm[31:0]));
      chk("imm64", b64.Immediate_o, mq[0].imm);
      chk("tag32", 64'(b32.Tag_o), 64'(mq[0].tag));
      chk("tag64", 64'(b64.Tag_o), 64'(mq[0].tag));
`ifdef IMM_ILLEGAL_EN
      chk("ill32", 64'(b32.Illegal_o), 64'(mq[0].ill));
      chk("ill64", 64'(b64.Illegal_o), 64'(mq[0].ill));
`endif
    end
  endtask

  // One clock: advance the model on the edge using the inputs held across it.
  task automatic step();
    ent_t e;
    logic rdy_pre;
    @(posedge clk);
    if (rst_n) begin
      rdy_pre = (mq.size() < 2);
      if (flush) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && r_i) void'(mq.pop_front());
        if (v_i && rdy_pre) begin
          e.imm = ref_imm(ins, fmt);
          e.tag = tag;
          e.ill = ref_ill(ins, fmt);
          mq.push_back(e);
        end
      end
    end
    #1;
    compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
    tv[1] = '{32'hFE20AE23, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC};
    tv[2] = '{32'h123450B7, 3'd4, 32'h12345000, 64'h00000000_12345000};
    tv[3] = '{32'hFFFFF06F, 3'd5, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFE};
    tv[4] = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC};
    tv[5] = '{32'h800000B7, 3'd4, 32'h80000000, 64'hFFFFFFFF_80000000};
    tv[6] = '{32'h7FF00093, 3'd1, 32'h000007FF, 64'h00000000_000007FF};
    tv[7] = '{32'hFE20AE33, 3'd0, 32'h00000000, 64'h0};
    tv[8] = '{32'hFFFFFFFF, 3'd6, 32'h00000000, 64'h0};
    tv[9] = '{32'h00100093, 3'd1, 32'h00000001, 64'h1};

    #1 rst_n = 1'b0;
    #11;
    chk("rst_valid32", 64'(b32.Valid_o), 64'd0);
    chk("rst_valid64", 64'(b64.Valid_o), 64'd0);
    chk("rst_ready32", 64'(b32.Ready_o), 64'd1);
    chk("rst_ready64", 64'(b64.Ready_o), 64'd1);
    chk("rst_imm32", 64'(b32.Immediate_o), 64'd0);
    chk("rst_imm64", b64.Immediate_o, 64'd0);
    chk("rst_tag32", 64'(b32.Tag_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode vectors, one per cycle with Ready_i held high.
    for (int i = 0; i < 10; i++) begin
      ins = tv[i].ins; fmt = tv[i].fmt; tag = TW'(i + 1); v_i = 1'b1; r_i = 1'b1;
      step();
      chk("tbl_valid", 64'(b32.Valid_o), 64'd1);
      chk("tbl_imm32", 64'(b32.Immediate_o), 64'(tv[i].e32));
      chk("tbl_imm64", b64.Immediate_o, tv[i].e64);
      chk("tbl_tag", 64'(b64.Tag_o), 64'(i + 1));
    end
    v_i = 1'b0;
    step();

`ifdef IMM_ILLEGAL_EN
    ins = 32'hFFF00093; fmt = 3'd7; v_i = 1'b1; tag = TW'(77);
    step();
    chk("ill_fmt7", 64'(b32.Illegal_o), 64'd1);
    chk("ill_fmt7_imm", b64.Immediate_o, 64'd0);
    ins = 32'hFFF00090; fmt = 3'd1;
    step();
    chk("ill_opc", 64'(b64.Illegal_o), 64'd1);
    chk("ill_opc_imm", 64'(b32.Immediate_o), 64'd0);
    v_i = 1'b0;
    step();
`endif

    // Backpressure: tags 1,2,3 offered with Ready_i low for four cycles.
    v_i = 1'b0; r_i = 1'b1;
    step(); step();
    ins = 32'h00100093; fmt = 3'd1; r_i = 1'b0; v_i = 1'b1; tag = TW'(1);
    step();
    chk("bp_ready_one", 64'(b32.Ready_o), 64'd1);
    tag = TW'(2);
    step();
    chk("bp_ready_drop", 64'(b32.Ready_o), 64'd0);
    tag = TW'(3);
    step(); step();
    chk("bp_hold_tag", 64'(b32.Tag_o), 64'd1);
    r_i = 1'b1;
    step();
    chk("bp_order2", 64'(b32.Tag_o), 64'd2);
    step();
    chk("bp_order3", 64'(b64.Tag_o), 64'd3);
    chk("bp_valid3", 64'(b64.Valid_o), 64'd1);
    v_i = 1'b0;
    step();
    chk("bp_drained", 64'(b32.Valid_o), 64'd0);

    // Flush with both entries full and an input offered.
    r_i = 1'b0; v_i = 1'b1; tag = TW'(10);
    step();
    tag = TW'(11);
    step();
    flush = 1'b1; tag = TW'(12);
    step();
    chk("fl_valid", 64'(b32.Valid_o), 64'd0);
    chk("fl_ready", 64'(b64.Ready_o), 64'd1);
    flush = 1'b0; v_i = 1'b0; r_i = 1'b1;
    step();
    chk("fl_gone", 64'(b64.Valid_o), 64'd0);

    // Randomized traffic with a mid-stream asynchronous reset.
    for (int n = 0; n < 400; n++) begin
      v_i   = (($urandom % 10) < 7);
      r_i   = (($urandom % 4) != 0);
      flush = (($urandom % 25) == 0);
      fmt   = 3'($urandom % 8);
      ins   = $urandom;
      if (($urandom % 8) != 0) ins[1:0] = 2'b11;
      tag   = TW'($urandom);
      step();
      if (n == 200) begin
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        chk("arst_valid32", 64'(b32.Valid_o), 64'd0);
        chk("arst_valid64", 64'(b64.Valid_o), 64'd0);
        chk("arst_ready", 64'(b32.Ready_o), 64'd1);
        #4 rst_n = 1'b1;
      end
    end
    flush = 1'b0; v_i = 1'b0; r_i = 1'b1;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
